// File: rtl/dmm_capture_pkg.sv
// Shared FSM state type and pio_0 ctrl/status bit positions for the capture writer.
package dmm_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_CONT      = 2;
  localparam int CTRL_DEPTH_LSB = 16;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_PTR_LSB = 4;
  localparam int ST_FRM_LSB = 16;

  // Written words carry the low frame-count bits above the sample.
  localparam int TAG_W = 4;

endpackage

// File: rtl/dmm_capture_writer_if.sv
// RAM s2 write port bundle; master drives it, the RAM side consumes it.
interface dmm_capture_writer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [1:0]        mem_byteenable;

  modport master (
    output mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata, mem_byteenable
  );

  modport slave (
    input mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata, mem_byteenable
  );
endinterface

// File: rtl/dmm_decimator.sv
// Sums 2^DECIM_LOG2 samples and emits the truncated average combinationally with the last one.
// Zero added latency; no backpressure, every in_vld_i strobe is absorbed.
module dmm_decimator #(
  parameter int SAMPLE_W   = 12,
  parameter int DECIM_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                in_vld_i,
  input  logic [SAMPLE_W-1:0] in_dat_i,
  output logic                out_vld_o,
  output logic [SAMPLE_W-1:0] out_dat_o
);
  localparam int ACC_W = SAMPLE_W + DECIM_LOG2;

  logic [ACC_W-1:0]      acc_q, acc_d, sum;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;

  assign sum = acc_q + ACC_W'(in_dat_i);

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_vld_o = 1'b0;
    out_dat_o = sum[ACC_W-1:DECIM_LOG2];
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_vld_i) begin
      if (cnt_q == {DECIM_LOG2{1'b1}}) begin
        out_vld_o = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + DECIM_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/dmm_capture_writer.sv
// ADC sample capture into RAM s2: one registered write per accepted word, 1 cycle after smp_valid, no backpressure.
// Optional averaging front end enabled by DMM_CAPTURE_DECIM_EN.
module dmm_capture_writer
  import dmm_capture_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int SAMPLE_W   = 12,
  parameter int DECIM_LOG2 = 2
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [31:0]         ctrl_word,
  output logic [31:0]         status_word,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  dmm_capture_writer_if.master mem
);

  state_e            state_q, state_d;
  logic              start_q, start_prev_q;
  logic              cont_in_q;
  logic [ADDR_W-1:0] depth_in_q;
  logic              cont_q, cont_d;
  logic [ADDR_W-1:0] depth_q, depth_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       frame_q, frame_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic                start_edge, abort, capt_in_vld;
  logic                word_vld;
  logic [SAMPLE_W-1:0] word_dat;
  logic [DATA_W-1:0]   word_pack;
  logic                unused_ctrl;

  assign start_edge  = start_q & ~start_prev_q;
  // Abort acts on the live pin so a sample in the same cycle is already suppressed.
  assign abort       = ctrl_word[CTRL_ABORT];
  assign capt_in_vld = smp_valid & (state_q == S_CAPT) & ~abort;
  assign unused_ctrl = ^{ctrl_word[31:CTRL_DEPTH_LSB+ADDR_W], ctrl_word[CTRL_DEPTH_LSB-1:CTRL_CONT+1]};

`ifdef DMM_CAPTURE_DECIM_EN
  dmm_decimator #(
    .SAMPLE_W  (SAMPLE_W),
    .DECIM_LOG2(DECIM_LOG2)
  ) u_decim (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .clr_i    (abort | (start_edge & (state_q != S_CAPT))),
    .in_vld_i (capt_in_vld),
    .in_dat_i (smp_data),
    .out_vld_o(word_vld),
    .out_dat_o(word_dat)
  );
`else
  logic [31:0] unused_decim;
  assign unused_decim = DECIM_LOG2;
  assign word_vld     = capt_in_vld;
  assign word_dat     = smp_data;
`endif

  always_comb begin
    word_pack                        = '0;
    word_pack[SAMPLE_W-1:0]          = word_dat;
    word_pack[DATA_W-1 -: TAG_W]     = frame_q[TAG_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    depth_d = depth_q;
    ptr_d   = ptr_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    frame_d = frame_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            state_d = S_CAPT;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            ptr_d   = '0;
            depth_d = depth_in_q;
            cont_d  = cont_in_q;
          end
        end
        S_CAPT: begin
          if (word_vld) begin
            wr_d   = 1'b1;
            addr_d = ptr_q;
            data_d = word_pack;
            ptr_d  = ptr_q + ADDR_W'(1);
            if (ptr_q == depth_q) begin
              done_d  = 1'b1;
              frame_d = frame_q + 16'd1;
              if (cont_q) begin
                ptr_d = '0;
                if (done_q) ovf_d = 1'b1;
              end else begin
                state_d = S_DONE;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      cont_in_q    <= 1'b0;
      depth_in_q   <= '0;
    end else begin
      start_q      <= ctrl_word[CTRL_START];
      start_prev_q <= start_q;
      cont_in_q    <= ctrl_word[CTRL_CONT];
      depth_in_q   <= ctrl_word[CTRL_DEPTH_LSB +: ADDR_W];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      cont_q  <= 1'b0;
      depth_q <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      frame_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      depth_q <= depth_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      frame_q <= frame_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    status_word                           = '0;
    status_word[ST_BUSY]                  = (state_q == S_CAPT);
    status_word[ST_DONE]                  = done_q;
    status_word[ST_OVF]                   = ovf_q;
    status_word[ST_PTR_LSB +: ADDR_W]     = ptr_q;
    status_word[ST_FRM_LSB +: 16]         = frame_q;
  end

  assign mem.mem_address    = addr_q;
  assign mem.mem_chipselect = wr_q;
  assign mem.mem_write      = wr_q;
  assign mem.mem_writedata  = data_q;
  assign mem.mem_clken      = 1'b1;
  assign mem.mem_byteenable = 2'b11;

endmodule
